// File: rtl/ad_tlc549_ctrl.sv
// TLC549 serial ADC sampler: periodic three-wire read of 8-bit results into the transmit FIFO.
// The first frame after reset is discarded; lost samples are flagged on drop/overrun.
module ad_tlc549_ctrl #(
  parameter int unsigned F_CLK         = 50_000_000,
  parameter int unsigned SCLK_HALF     = 25,
  parameter int unsigned CS_SETUP      = 75,
  parameter int unsigned CONV_WAIT     = 1000,
  parameter int unsigned SAMPLE_PERIOD = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ad_dout,
  input  logic       full,
  output logic       ad_cs_n,
  output logic       ad_clk,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_data_in,
  output logic       drop,
  output logic       overrun
);

  if (F_CLK == 0 || SCLK_HALF < 1 || SCLK_HALF > 65535 || CS_SETUP < 1 || CS_SETUP > 65535 ||
      CONV_WAIT < 1 || CONV_WAIT > 65535 || SAMPLE_PERIOD < 1 || SAMPLE_PERIOD > 65535)
  begin : g_bad_params
    $error("ad_tlc549_ctrl: parameter out of range");
  end

  localparam logic [15:0] PeriodLast = 16'(SAMPLE_PERIOD - 1);
  localparam logic [15:0] SetupLast  = 16'(CS_SETUP - 1);
  localparam logic [15:0] HalfLast   = 16'(SCLK_HALF - 1);
  localparam logic [15:0] WaitLast   = 16'(CONV_WAIT - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StWrite, StHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] period_q, period_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  half_q, half_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        primed_q, primed_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        tick;
  logic        wr_en;
  logic        drop_w;

  always_comb begin
    tick     = (period_q == PeriodLast);
    period_d = tick ? 16'd0 : period_q + 16'd1;

    state_d  = state_q;
    timer_d  = timer_q + 16'd1;
    half_d   = half_q;
    shift_d  = shift_q;
    data_d   = data_q;
    primed_d = primed_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    wr_en    = 1'b0;
    drop_w   = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = 16'd0;
        if (tick) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
        end
      end
      StSetup: begin
        if (timer_q == SetupLast) begin
          timer_d = 16'd0;
          half_d  = 4'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (timer_q == HalfLast) begin
          timer_d = 16'd0;
          half_d  = half_q + 4'd1;
          if (half_q == 4'd15) begin
            // End of the 8th high phase: releasing CS starts the next conversion.
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            state_d = StWrite;
          end else begin
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              shift_d = {shift_q[6:0], ad_dout};
            end
          end
        end
      end
      StWrite: begin
        timer_d  = 16'd0;
        primed_d = 1'b1;
        state_d  = StHold;
        if (primed_q) begin
          if (full) begin
            drop_w = 1'b1;
          end else begin
            wr_en  = 1'b1;
            data_d = shift_q;
          end
        end
      end
      StHold: begin
        if (timer_q == WaitLast) begin
          timer_d = 16'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      period_q <= 16'd0;
      timer_q  <= 16'd0;
      half_q   <= 4'd0;
      shift_q  <= 8'd0;
      data_q   <= 8'd0;
      primed_q <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      timer_q  <= timer_d;
      half_q   <= half_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      primed_q <= primed_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
    end
  end

  assign ad_cs_n      = cs_n_q;
  assign ad_clk       = sclk_q;
  assign fifo_wr_en   = wr_en;
  assign drop         = drop_w;
  assign overrun      = tick && (state_q != StIdle);
  // The new byte is presented in the write cycle itself, then held in data_q.
  assign fifo_data_in = wr_en ? shift_q : data_q;

endmodule

// File: tb/tb_ad_tlc549_ctrl.sv
// Bench for ad_tlc549_ctrl: TLC549 behavioural model plus a frame-level reference model
// derived from the sample-period and frame timing rules, using scaled-down parameters.
module tb_ad_tlc549_ctrl;

  localparam int SH  = 3;
  localparam int CS  = 5;
  localparam int CW  = 10;
  localparam int P   = 120;
  localparam int P2  = 40;
  localparam int LOW = CS + 16 * SH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ad_dout;
  logic       full = 1'b0;
  logic       ad_cs_n, ad_clk, fifo_wr_en, drop, overrun;
  logic [7:0] fifo_data_in;

  logic       ad_dout2 = 1'b0;
  logic       full2 = 1'b0;
  logic       cs2_n, clk2, wr2, drop2, ovr2;
  logic [7:0] data2;

  int         checks = 0;
  int         failures = 0;
  int         cyc;
  logic [7:0] frame_val [64];
  logic [7:0] m_data;

  logic [5:0] adc_frame;
  logic [7:0] adc_sr;
  logic       adc_loaded;

  ad_tlc549_ctrl #(
    .F_CLK(50_000_000), .SCLK_HALF(SH), .CS_SETUP(CS), .CONV_WAIT(CW), .SAMPLE_PERIOD(P)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ad_dout(ad_dout), .full(full), .ad_cs_n(ad_cs_n),
    .ad_clk(ad_clk), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .drop(drop),
    .overrun(overrun)
  );

  ad_tlc549_ctrl #(
    .F_CLK(50_000_000), .SCLK_HALF(SH), .CS_SETUP(CS), .CONV_WAIT(CW), .SAMPLE_PERIOD(P2)
  ) u_dut_ovr (
    .clk(clk), .rst_n(rst_n), .ad_dout(ad_dout2), .full(full2), .ad_cs_n(cs2_n),
    .ad_clk(clk2), .fifo_wr_en(wr2), .fifo_data_in(data2), .drop(drop2), .overrun(ovr2)
  );

  always #5 clk = ~clk;

  // Interval index since reset release; matches the DUT period count modulo P.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // TLC549: MSB appears when CS falls, next bit after each falling I/O clock.
  always @(negedge rst_n or negedge ad_cs_n or posedge ad_cs_n or negedge ad_clk) begin
    if (!rst_n) begin
      adc_frame  <= 6'd0;
      adc_loaded <= 1'b0;
      ad_dout    <= 1'b0;
    end else if (ad_cs_n) begin
      adc_loaded <= 1'b0;
    end else if (!adc_loaded) begin
      ad_dout    <= frame_val[adc_frame][7];
      adc_sr     <= frame_val[adc_frame] << 1;
      adc_frame  <= adc_frame + 6'd1;
      adc_loaded <= 1'b1;
    end else begin
      ad_dout <= adc_sr[7];
      adc_sr  <= adc_sr << 1;
    end
  end

  // Expected {cs_n, ad_clk, wr_en, drop, overrun, data} for interval c of the main DUT.
  function automatic logic [12:0] model_out(input int c, input logic f);
    logic cs_n, sck, wr, dr;
    int   k, o;
    cs_n = 1'b1;
    sck  = 1'b0;
    wr   = 1'b0;
    dr   = 1'b0;
    if (c >= P) begin
      k = (c - P) / P;
      o = c - (k * P + P - 1);
      if (o <= LOW) cs_n = 1'b0;
      if (o > CS && o <= LOW && ((o - CS - 1) / SH) % 2 == 1) sck = 1'b1;
      if (o == LOW + 1 && k >= 1) begin
        if (f) begin
          dr = 1'b1;
        end else begin
          wr     = 1'b1;
          m_data = frame_val[k[5:0]];
        end
      end
    end
    return {cs_n, sck, wr, dr, 1'b0, m_data};
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    full   = 1'b0;
    m_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) frame_val[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 3; r++) begin
      obs = {ad_cs_n, ad_clk, fifo_wr_en, drop, overrun, fifo_data_in};
      checks++;
      if (obs !== 13'h1000) begin
        failures++;
        $display("FAIL reset_main got=%b exp=%b", obs, 13'h1000);
      end
      obs = {cs2_n, clk2, wr2, drop2, ovr2, data2};
      checks++;
      if (obs !== 13'h1000) begin
        failures++;
        $display("FAIL reset_ovr got=%b exp=%b", obs, 13'h1000);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_first_discard();
    logic [12:0] exp, obs;
    logic [7:0]  wlog[$];
    fill_random();
    frame_val[0] = 8'h3C;
    frame_val[1] = 8'hA5;
    frame_val[2] = 8'h5A;
    do_reset();
    repeat (4 * P) begin
      @(negedge clk);
      #1;
      exp = model_out(cyc, full);
      obs = {ad_cs_n, ad_clk, fifo_wr_en, drop, overrun, fifo_data_in};
      if (fifo_wr_en) wlog.push_back(fifo_data_in);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL first_discard cyc=%0d got=%b exp=%b", cyc, obs, exp);
      end
    end
    checks++;
    if (wlog.size() != 2 || wlog[0] !== 8'hA5 || wlog[1] !== 8'h5A) begin
      failures++;
      $display("FAIL first_discard_log got=%p exp='{a5,5a}", wlog);
    end
  endtask

  task automatic test_timing();
    int    got[6], want[6];
    string nm[6];
    int    fall_c = -1, rise_c = -1, wr_c = -1, rises = 0, first_r = -1, last_r = -1;
    int    t1;
    logic  pcs = 1'b1, psck = 1'b0;
    fill_random();
    do_reset();
    repeat (3 * P) begin
      @(negedge clk);
      #1;
      if (cyc >= 2 * P && cyc < 3 * P) begin
        if (!ad_cs_n && pcs && fall_c < 0) fall_c = cyc;
        if (ad_cs_n && !pcs && rise_c < 0) rise_c = cyc;
        if (ad_clk && !psck) begin
          rises++;
          if (first_r < 0) first_r = cyc;
          last_r = cyc;
        end
        if (fifo_wr_en) wr_c = cyc;
      end
      pcs  = ad_cs_n;
      psck = ad_clk;
    end
    t1 = 2 * P - 1;
    nm[0] = "cs_fall";    got[0] = fall_c;          want[0] = t1 + 1;
    nm[1] = "cs_rise";    got[1] = rise_c;          want[1] = t1 + 1 + LOW;
    nm[2] = "sclk_rises"; got[2] = rises;           want[2] = 8;
    nm[3] = "first_rise"; got[3] = first_r;         want[3] = t1 + 1 + CS + SH;
    nm[4] = "rise_span";  got[4] = last_r - first_r; want[4] = 14 * SH;
    nm[5] = "wr_cycle";   got[5] = wr_c;            want[5] = t1 + 1 + LOW;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("FAIL timing_%s got=%0d exp=%0d", nm[i], got[i], want[i]);
      end
    end
  endtask

  task automatic test_full_drop();
    logic [12:0] exp, obs;
    logic [7:0]  wlog[$];
    int          drops = 0;
    fill_random();
    frame_val[1] = 8'h11;
    frame_val[2] = 8'h81;
    frame_val[3] = 8'h42;
    do_reset();
    repeat (5 * P) begin
      @(negedge clk);
      full = (cyc >= 3 * P && cyc < 4 * P);
      #1;
      exp = model_out(cyc, full);
      obs = {ad_cs_n, ad_clk, fifo_wr_en, drop, overrun, fifo_data_in};
      if (fifo_wr_en) wlog.push_back(fifo_data_in);
      if (drop) begin
        drops++;
        checks++;
        if (fifo_data_in !== 8'h11) begin
          failures++;
          $display("FAIL drop_hold got=%h exp=11", fifo_data_in);
        end
      end
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL full_drop cyc=%0d got=%b exp=%b", cyc, obs, exp);
      end
    end
    full = 1'b0;
    checks++;
    if (drops != 1) begin
      failures++;
      $display("FAIL drop_count got=%0d exp=1", drops);
    end
    checks++;
    if (wlog.size() != 2 || wlog[0] !== 8'h11 || wlog[1] !== 8'h42) begin
      failures++;
      $display("FAIL full_drop_log got=%p exp='{11,42}", wlog);
    end
  endtask

  task automatic test_patterns();
    logic [12:0] exp, obs;
    logic [7:0]  wlog[$];
    fill_random();
    frame_val[1] = 8'h00;
    frame_val[2] = 8'hFF;
    frame_val[3] = 8'h80;
    do_reset();
    repeat (4 * P + 60) begin
      @(negedge clk);
      #1;
      exp = model_out(cyc, full);
      obs = {ad_cs_n, ad_clk, fifo_wr_en, drop, overrun, fifo_data_in};
      if (fifo_wr_en) wlog.push_back(fifo_data_in);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL patterns cyc=%0d got=%b exp=%b", cyc, obs, exp);
      end
    end
    checks++;
    if (wlog.size() != 3 || wlog[0] !== 8'h00 || wlog[1] !== 8'hFF || wlog[2] !== 8'h80) begin
      failures++;
      $display("FAIL patterns_log got=%p exp='{00,ff,80}", wlog);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp, obs;
    fill_random();
    do_reset();
    repeat (11 * P) begin
      @(negedge clk);
      full = ($urandom_range(0, 3) == 0);
      #1;
      exp = model_out(cyc, full);
      obs = {ad_cs_n, ad_clk, fifo_wr_en, drop, overrun, fifo_data_in};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp);
      end
    end
    full = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [12:0] exp, obs;
    logic [7:0]  wlog[$];
    fill_random();
    do_reset();
    // Lands in the 4th high phase of the first primed frame.
    repeat (2 * P + 27) begin
      @(negedge clk);
      #1;
      exp = model_out(cyc, full);
      obs = {ad_cs_n, ad_clk, fifo_wr_en, drop, overrun, fifo_data_in};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL midframe_pre cyc=%0d got=%b exp=%b", cyc, obs, exp);
      end
    end
    checks++;
    if ({ad_cs_n, ad_clk} !== 2'b01) begin
      failures++;
      $display("FAIL midframe_phase got=%b exp=01", {ad_cs_n, ad_clk});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ad_cs_n, ad_clk} !== 2'b10) begin
      failures++;
      $display("FAIL midframe_async got=%b exp=10", {ad_cs_n, ad_clk});
    end
    fill_random();
    m_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * P + 60) begin
      @(negedge clk);
      #1;
      exp = model_out(cyc, full);
      obs = {ad_cs_n, ad_clk, fifo_wr_en, drop, overrun, fifo_data_in};
      if (fifo_wr_en) wlog.push_back(fifo_data_in);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL midframe_post cyc=%0d got=%b exp=%b", cyc, obs, exp);
      end
    end
    checks++;
    if (wlog.size() != 2 || wlog[0] !== frame_val[1]) begin
      failures++;
      $display("FAIL midframe_log got=%p exp_first=%h count=2", wlog, frame_val[1]);
    end
  endtask

  task automatic test_overrun();
    logic [2:0] exp, obs;
    int idle_at = 0, ft = -1000, started = 0, ovr_exp = 0, ovr_obs = 0;
    logic e_cs, e_wr, e_ovr;
    fill_random();
    do_reset();
    repeat (8 * P2) begin
      @(negedge clk);
      #1;
      e_ovr = 1'b0;
      if (cyc % P2 == P2 - 1) begin
        if (cyc >= idle_at) begin
          ft      = cyc;
          idle_at = cyc + 2 + LOW + CW;
          started++;
        end else begin
          e_ovr = 1'b1;
          ovr_exp++;
        end
      end
      e_cs = !(cyc >= ft + 1 && cyc <= ft + LOW);
      e_wr = (cyc == ft + LOW + 1) && (started >= 2);
      exp  = {e_cs, e_wr, e_ovr};
      obs  = {cs2_n, wr2, ovr2};
      if (ovr2) ovr_obs++;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL overrun cyc=%0d got=%b exp=%b", cyc, obs, exp);
      end
    end
    checks++;
    if (ovr_obs != ovr_exp) begin
      failures++;
      $display("FAIL overrun_count got=%0d exp=%0d", ovr_obs, ovr_exp);
    end
  endtask

  initial begin
    m_data = 8'h00;
    for (int i = 0; i < 64; i++) frame_val[i] = 8'h00;
    #2;
    test_reset();
    test_first_discard();
    test_timing();
    test_full_drop();
    test_patterns();
    test_random();
    test_reset_midframe();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
